// File: rtl/mips_wb_pkg.sv
// Shared writeback constants: source selects, load opcodes, HI/LO funcs.
// Imported by the writeback stage and its load extender.
package mips_wb_pkg;

  typedef enum logic [2:0] {
    WSEL_ALU  = 3'd0,
    WSEL_LOAD = 3'd1,
    WSEL_LINK = 3'd2,
    WSEL_HI   = 3'd3,
    WSEL_LO   = 3'd4,
    WSEL_RS   = 3'd5,
    WSEL_RSV6 = 3'd6,
    WSEL_RSV7 = 3'd7
  } wsel_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

endpackage

// File: rtl/load_ext.sv
// Little-endian byte/half extraction and extension of a loaded word.
// Offset comes from the low bits of the load address.
module load_ext
  import mips_wb_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (opcode)
      OP_LB:   data = {{24{b[7]}}, b};
      OP_LBU:  data = {24'h0, b};
      OP_LH:   data = {{16{h[15]}}, h};
      OP_LHU:  data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: regfile write mux, HI/LO registers, forwarding copy
// of the last regfile write, and a retired-instruction counter.
module wb_unit
  import mips_wb_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_ram_out,
  input  logic [31:0] mem_rdata1,
  input  logic [63:0] mem_hilo_out,
  input  logic [2:0]  mem_rf_wsel,
  input  logic        mem_rf_nwe,
  input  logic [4:0]  mem_rd,
  input  logic [5:0]  mem_opcode,
  input  logic [5:0]  mem_func,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] retired
);

  logic [31:0] load_data;
  logic        live;
  logic        wr_hilo;
  logic        wr_hi;
  logic        wr_lo;

  load_ext u_load_ext (
    .opcode (mem_opcode),
    .offset (mem_alu_out[1:0]),
    .word   (mem_ram_out),
    .data   (load_data)
  );

  assign rf_we    = ~mem_rf_nwe & (|mem_rd);
  assign rf_waddr = mem_rd;
  assign live     = |mem_pc;

  always_comb begin
    unique case (wsel_e'(mem_rf_wsel))
      WSEL_LOAD: rf_wdata = load_data;
      WSEL_LINK: rf_wdata = mem_pc + 32'd8;
      WSEL_HI:   rf_wdata = hi;
      WSEL_LO:   rf_wdata = lo;
      WSEL_RS:   rf_wdata = mem_rdata1;
      default:   rf_wdata = mem_alu_out;
    endcase
  end

  // Only real special-class instructions touch HI/LO; bubbles never do.
  always_comb begin
    wr_hilo = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    if (live && mem_opcode == OP_SPECIAL) begin
      unique case (1'b1)
        mem_func == FN_MULT,
        mem_func == FN_MULTU,
        mem_func == FN_DIV,
        mem_func == FN_DIVU: wr_hilo = 1'b1;
        mem_func == FN_MTHI: wr_hi = 1'b1;
        mem_func == FN_MTLO: wr_lo = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi        <= '0;
      lo        <= '0;
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
      retired   <= '0;
    end else begin
      if (wr_hilo) begin
        hi <= mem_hilo_out[63:32];
        lo <= mem_hilo_out[31:0];
      end
      if (wr_hi) hi <= mem_rdata1;
      if (wr_lo) lo <= mem_rdata1;
      fwd_valid <= rf_we;
      fwd_rd    <= rf_waddr;
      fwd_data  <= rf_wdata;
      if (live) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed corner cases then
// randomized traffic against a behavioural writeback model.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_pc;
  logic [31:0] mem_alu_out;
  logic [31:0] mem_ram_out;
  logic [31:0] mem_rdata1;
  logic [63:0] mem_hilo_out;
  logic [2:0]  mem_rf_wsel;
  logic        mem_rf_nwe;
  logic [4:0]  mem_rd;
  logic [5:0]  mem_opcode;
  logic [5:0]  mem_func;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_hi, m_lo, m_ret, m_fd;
  logic        m_fv;
  logic [4:0]  m_frd;

  always #5 clk = ~clk;

  wb_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_pc       (mem_pc),
    .mem_alu_out  (mem_alu_out),
    .mem_ram_out  (mem_ram_out),
    .mem_rdata1   (mem_rdata1),
    .mem_hilo_out (mem_hilo_out),
    .mem_rf_wsel  (mem_rf_wsel),
    .mem_rf_nwe   (mem_rf_nwe),
    .mem_rd       (mem_rd),
    .mem_opcode   (mem_opcode),
    .mem_func     (mem_func),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .hi           (hi),
    .lo           (lo),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retired      (retired)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_load(input logic [5:0] op,
                                         input logic [1:0] off,
                                         input logic [31:0] w);
    int unsigned bv, hv;
    bv = (w >> (int'(off) * 8)) & 32'hFF;
    hv = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
    case (op)
      6'h20:   return (bv > 127) ? 32'(int'(bv) - 256) : bv;
      6'h24:   return bv;
      6'h21:   return (hv > 32767) ? 32'(int'(hv) - 65536) : hv;
      6'h25:   return hv;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata();
    case (int'(mem_rf_wsel))
      1:       return m_load(mem_opcode, mem_alu_out[1:0], mem_ram_out);
      2:       return 32'((64'(mem_pc) + 64'd8) % 64'h1_0000_0000);
      3:       return m_hi;
      4:       return m_lo;
      5:       return mem_rdata1;
      default: return mem_alu_out;
    endcase
  endfunction

  task automatic idle();
    resetn       = 1'b1;
    mem_pc       = '0;
    mem_alu_out  = '0;
    mem_ram_out  = '0;
    mem_rdata1   = '0;
    mem_hilo_out = '0;
    mem_rf_wsel  = '0;
    mem_rf_nwe   = 1'b1;
    mem_rd       = '0;
    mem_opcode   = '0;
    mem_func     = '0;
  endtask

  // Inputs are already applied just after a falling edge.
  task automatic cycle(input string tag);
    logic        ewe;
    logic [31:0] ewd;
    #1;
    ewe = (mem_rf_nwe == 1'b0) && (mem_rd != 0);
    ewd = m_wdata();
    chk({tag, ".we"}, 64'(rf_we), 64'(ewe));
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'(mem_rd));
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'(ewd));
    @(posedge clk);
    if (!resetn) begin
      m_hi = 0; m_lo = 0; m_ret = 0;
      m_fv = 0; m_frd = 0; m_fd = 0;
    end else begin
      if (mem_pc != 0 && mem_opcode == 0) begin
        if (mem_func >= 6'h18 && mem_func <= 6'h1B) begin
          m_hi = mem_hilo_out[63:32];
          m_lo = mem_hilo_out[31:0];
        end else if (mem_func == 6'h11) m_hi = mem_rdata1;
        else if (mem_func == 6'h13) m_lo = mem_rdata1;
      end
      m_fv = ewe; m_frd = mem_rd; m_fd = ewd;
      if (mem_pc != 0) m_ret = m_ret + 1;
    end
    @(negedge clk);
    chk({tag, ".hi"}, 64'(hi), 64'(m_hi));
    chk({tag, ".lo"}, 64'(lo), 64'(m_lo));
    chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(m_fv));
    chk({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(m_frd));
    chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(m_fd));
    chk({tag, ".retired"}, 64'(retired), 64'(m_ret));
  endtask

  task automatic ld(input logic [5:0] op, input logic [31:0] word,
                    input logic [1:0] off, input string tag);
    idle();
    mem_pc = 32'h400; mem_opcode = op; mem_ram_out = word;
    mem_alu_out = {30'h1000, off}; mem_rf_wsel = 3'd1;
    mem_rd = 5'd5; mem_rf_nwe = 1'b0;
    cycle(tag);
  endtask

  logic [5:0] ops [7];
  logic [5:0] fns [8];

  initial begin
    ops = '{6'h00, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h0F};
    fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13, 6'h10, 6'h20};
    m_hi = 'x; m_lo = 'x; m_ret = 'x; m_fv = 'x; m_frd = 'x; m_fd = 'x;

    @(negedge clk);
    idle(); resetn = 1'b0;
    cycle("reset");

    @(negedge clk);
    ld(6'h20, 32'h80FF7F01, 2'd3, "lb");
    ld(6'h24, 32'h80FF7F01, 2'd3, "lbu");
    ld(6'h21, 32'h80011234, 2'd2, "lh");
    ld(6'h25, 32'h80011234, 2'd2, "lhu");
    ld(6'h23, 32'h80011234, 2'd1, "lw");

    idle();
    mem_pc = 32'h500; mem_func = 6'h18;
    mem_hilo_out = 64'h00000001_FFFFFFFE;
    cycle("mult");
    idle();
    mem_pc = 32'h504; mem_rf_wsel = 3'd3; mem_rd = 5'd2; mem_rf_nwe = 1'b0;
    mem_func = 6'h10;
    cycle("mfhi");
    idle();
    mem_pc = 32'h508; mem_func = 6'h13; mem_rdata1 = 32'hDEADBEEF;
    cycle("mtlo");
    idle();
    mem_pc = 32'h50C; mem_func = 6'h11; mem_rdata1 = 32'h12345678;
    mem_rf_wsel = 3'd4; mem_rd = 5'd3; mem_rf_nwe = 1'b0;
    cycle("mthi_mflo");

    idle();
    mem_pc = 32'hFFFFFFFC; mem_rf_wsel = 3'd2; mem_rd = 5'd31;
    mem_rf_nwe = 1'b0; mem_opcode = 6'h03;
    cycle("jal_wrap");

    idle();
    mem_pc = 32'h600; mem_rf_nwe = 1'b0; mem_rd = 5'd0;
    mem_alu_out = 32'h55;
    cycle("rd0");
    idle();
    mem_func = 6'h18; mem_hilo_out = 64'hAAAA_BBBB_CCCC_DDDD;
    cycle("bubble_mult");

    idle();
    mem_pc = 32'h700; mem_rd = 5'd9; mem_rf_nwe = 1'b0;
    mem_alu_out = 32'h77;
    force dut.retired = 32'hFFFFFFFF;
    #1;
    release dut.retired;
    m_ret = 32'hFFFFFFFF;
    cycle("retire_wrap");

    idle();
    resetn = 1'b0; mem_pc = 32'h800; mem_func = 6'h18;
    mem_hilo_out = 64'h1111_2222_3333_4444;
    cycle("reset_vs_mult");

    for (int i = 0; i < 400; i++) begin
      idle();
      resetn       = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 7))
        0, 1:    mem_pc = 32'h0;
        2:       mem_pc = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
        default: mem_pc = $urandom;
      endcase
      mem_alu_out  = $urandom;
      mem_ram_out  = $urandom;
      mem_rdata1   = $urandom;
      mem_hilo_out = {$urandom, $urandom};
      mem_rf_wsel  = 3'($urandom_range(0, 7));
      mem_rf_nwe   = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 31));
      mem_opcode   = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                     : ops[$urandom_range(0, 6)];
      mem_func     = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                     : fns[$urandom_range(0, 7)];
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
